bram_arbiter: RTL and testbench

Round-robin arbiter that shares one `bram_block` instance among `NUM_REQ` requesters, one access (read or byte-masked write) per cycle. It sits directly in front of `bram_block`, drives its `rd_addr`/`wr_addr`/`wr_en`/`din` ports, and returns `dout` to the requester that issued the read. Locked bursts let a requester keep the BRAM for up to `MAX_BURST` consecutive beats.

---
 rtl/bram_arbiter_if.sv | 36 +++
 rtl/bram_arbiter.sv | 143 ++++++++++++++
 tb/tb_bram_arbiter.sv | 227 ++++++++++++++++++++++
 3 files changed

// File: rtl/bram_arbiter_if.sv
// Requester-side and BRAM-side signal bundle for the round-robin BRAM arbiter.
// Per-requester fields are flattened, with requester i at slice i.
interface bram_arbiter_if #(
  parameter int BRAM_ADDR_WIDTH = 6,
  parameter int BRAM_DATA_WIDTH = 32,
  parameter int NUM_REQ         = 2
);
  localparam int BE_WIDTH = BRAM_DATA_WIDTH / 8;

  logic [NUM_REQ-1:0]                 req_valid;
  logic [NUM_REQ-1:0]                 req_ready;
  logic [NUM_REQ-1:0]                 req_write;
  logic [NUM_REQ-1:0]                 req_last;
  logic [NUM_REQ*BE_WIDTH-1:0]        req_be;
  logic [NUM_REQ*BRAM_ADDR_WIDTH-1:0] req_addr;
  logic [NUM_REQ*BRAM_DATA_WIDTH-1:0] req_wdata;
  logic [NUM_REQ-1:0]                 rsp_valid;
  logic [BRAM_DATA_WIDTH-1:0]         rsp_rdata;
  logic [BRAM_ADDR_WIDTH-1:0]         bram_rd_addr;
  logic [BRAM_ADDR_WIDTH-1:0]         bram_wr_addr;
  logic [BE_WIDTH-1:0]                bram_wr_en;
  logic [BRAM_DATA_WIDTH-1:0]         bram_din;
  logic [BRAM_DATA_WIDTH-1:0]         bram_dout;

  // The arbiter's view: requests and BRAM read data come in, grants/responses/BRAM controls go out.
  modport slave (
    input  req_valid, req_write, req_last, req_be, req_addr, req_wdata, bram_dout,
    output req_ready, rsp_valid, rsp_rdata, bram_rd_addr, bram_wr_addr, bram_wr_en, bram_din
  );

  // The environment's view: requesters plus the BRAM itself.
  modport master (
    output req_valid, req_write, req_last, req_be, req_addr, req_wdata, bram_dout,
    input  req_ready, rsp_valid, rsp_rdata, bram_rd_addr, bram_wr_addr, bram_wr_en, bram_din
  );
endinterface

// File: rtl/bram_arbiter.sv
// Round-robin arbiter sharing one bram_block among NUM_REQ requesters, one access per cycle,
// with locked bursts capped at MAX_BURST beats and a one-cycle read-return path.
module bram_arbiter #(
  parameter int BRAM_ADDR_WIDTH = 6,
  parameter int BRAM_DATA_WIDTH = 32,
  parameter int NUM_REQ         = 2,
  parameter int MAX_BURST       = 8
) (
  input logic           clock,
  input logic           reset,
  bram_arbiter_if.slave bus
);
  localparam int BE_WIDTH  = BRAM_DATA_WIDTH / 8;
  localparam int ID_WIDTH  = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
  localparam int CNT_WIDTH = $clog2(MAX_BURST + 1);

  typedef enum logic {UNLOCKED, LOCKED} state_t;

  state_t                     state, state_next;
  logic [ID_WIDTH-1:0]        prio_ptr, prio_next;
  logic [ID_WIDTH-1:0]        lock_id, lock_id_next;
  logic [CNT_WIDTH-1:0]       beat_cnt, beat_next, beat_inc;
  logic                       rsp_pend;
  logic [ID_WIDTH-1:0]        rsp_id;
  logic                       grant_any;
  logic [ID_WIDTH-1:0]        grant_id;
  logic [ID_WIDTH-1:0]        grant_succ;
  logic                       acc_write;
  logic                       acc_last;
  logic [BE_WIDTH-1:0]        acc_be;
  logic [BRAM_ADDR_WIDTH-1:0] acc_addr;
  logic [BRAM_DATA_WIDTH-1:0] acc_wdata;
  logic [BRAM_ADDR_WIDTH-1:0] rd_addr_q, wr_addr_q;
  logic [BRAM_DATA_WIDTH-1:0] din_q;

  assign acc_write  = bus.req_write[grant_id];
  assign acc_last   = bus.req_last[grant_id];
  assign acc_be     = bus.req_be[int'(grant_id)*BE_WIDTH +: BE_WIDTH];
  assign acc_addr   = bus.req_addr[int'(grant_id)*BRAM_ADDR_WIDTH +: BRAM_ADDR_WIDTH];
  assign acc_wdata  = bus.req_wdata[int'(grant_id)*BRAM_DATA_WIDTH +: BRAM_DATA_WIDTH];
  assign beat_inc   = beat_cnt + 1'b1;
  assign grant_succ = (int'(grant_id) == NUM_REQ - 1) ? '0 : grant_id + 1'b1;

  // FSM state register plus the burst/priority bookkeeping that moves with it.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state    <= UNLOCKED;
      prio_ptr <= '0;
      lock_id  <= '0;
      beat_cnt <= '0;
    end else begin
      state    <= state_next;
      prio_ptr <= prio_next;
      lock_id  <= lock_id_next;
      beat_cnt <= beat_next;
    end
  end

  // Next state: a last beat or the MAX_BURST-th beat releases, any other beat locks to the winner.
  always_comb begin
    state_next   = state;
    prio_next    = prio_ptr;
    lock_id_next = lock_id;
    beat_next    = beat_cnt;
    if (grant_any) begin
      if (acc_last || (beat_inc == CNT_WIDTH'(MAX_BURST))) begin
        state_next = UNLOCKED;
        beat_next  = '0;
        prio_next  = grant_succ;
      end else begin
        state_next   = LOCKED;
        lock_id_next = grant_id;
        beat_next    = beat_inc;
      end
    end
  end

  // FSM output: pick the winner; lower scan offset from prio_ptr wins, so scan from the far end down.
  always_comb begin
    int idx;
    grant_any = 1'b0;
    grant_id  = '0;
    idx       = 0;
    if (!reset) begin
      if (state == LOCKED) begin
        if (bus.req_valid[lock_id]) begin
          grant_any = 1'b1;
          grant_id  = lock_id;
        end
      end else begin
        for (int k = NUM_REQ - 1; k >= 0; k--) begin
          idx = (int'(prio_ptr) + k) % NUM_REQ;
          if (bus.req_valid[idx]) begin
            grant_any = 1'b1;
            grant_id  = ID_WIDTH'(idx);
          end
        end
      end
    end
  end

  // Read-return register and the held BRAM address/data shown while nobody is granted.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      rsp_pend  <= 1'b0;
      rsp_id    <= '0;
      rd_addr_q <= '0;
      wr_addr_q <= '0;
      din_q     <= '0;
    end else begin
      rsp_pend <= grant_any & ~acc_write;
      rsp_id   <= grant_id;
      if (grant_any && acc_write) begin
        wr_addr_q <= acc_addr;
        din_q     <= acc_wdata;
      end
      if (grant_any && !acc_write) begin
        rd_addr_q <= acc_addr;
      end
    end
  end

  // Ready is the one-hot grant, produced in the same cycle as the request.
  always_comb begin
    bus.req_ready           = '0;
    bus.req_ready[grant_id] = grant_any;
  end

  // Response valid points at the requester whose read was accepted last cycle.
  always_comb begin
    bus.rsp_valid         = '0;
    bus.rsp_valid[rsp_id] = rsp_pend;
  end

  // BRAM drive: the accepted beat goes straight through so a write lands on the edge ending its cycle.
  always_comb begin
    bus.bram_wr_en   = (grant_any && acc_write) ? acc_be : '0;
    bus.bram_wr_addr = (grant_any && acc_write) ? acc_addr : wr_addr_q;
    bus.bram_din     = (grant_any && acc_write) ? acc_wdata : din_q;
    bus.bram_rd_addr = (grant_any && !acc_write) ? acc_addr : rd_addr_q;
    bus.rsp_rdata    = rsp_pend ? bus.bram_dout : '0;
  end
endmodule

// File: tb/tb_bram_arbiter.sv
// Directed bench for bram_arbiter with a behavioural bram_block, a shadow memory and a read scoreboard.
module tb_bram_arbiter;
  localparam int AW = 6;
  localparam int DW = 32;
  localparam int NR = 2;
  localparam int MB = 8;

  typedef struct packed {
    logic [NR-1:0] id;
    logic [DW-1:0] data;
  } rsp_t;

  logic clock = 1'b0;
  logic reset = 1'b1;
  int   pass_cnt  = 0;
  int   fail_cnt  = 0;
  int   check_cnt = 0;
  rsp_t sb[$];
  logic [DW-1:0] shadow [0:63];
  logic [DW-1:0] bram_mem [0:63];

  bram_arbiter_if #(.BRAM_ADDR_WIDTH(AW), .BRAM_DATA_WIDTH(DW), .NUM_REQ(NR)) bus ();

  bram_arbiter #(
    .BRAM_ADDR_WIDTH(AW), .BRAM_DATA_WIDTH(DW), .NUM_REQ(NR), .MAX_BURST(MB)
  ) dut (
    .clock(clock),
    .reset(reset),
    .bus  (bus)
  );

  always #5 clock = ~clock;

  function automatic logic [DW-1:0] init_word(input int i);
    return 32'h5A00_0000 ^ (i * 32'h0001_0203);
  endfunction

  // Behavioural bram_block: byte-masked write, one-cycle registered read, preloaded during reset.
  always @(posedge clock) begin
    if (reset) begin
      for (int i = 0; i < 64; i++) bram_mem[i] <= init_word(i);
      bus.bram_dout <= '0;
    end else begin
      for (int b = 0; b < DW / 8; b++)
        if (bus.bram_wr_en[b]) bram_mem[bus.bram_wr_addr][8*b +: 8] <= bus.bram_din[8*b +: 8];
      bus.bram_dout <= bram_mem[bus.bram_rd_addr];
    end
  end

  // Watchdog so the run always terminates.
  initial begin
    #2_000_000;
    $display("[TB] FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic check(input string tag, input logic [63:0] observed, input logic [63:0] expected);
    check_cnt++;
    assert (observed === expected) pass_cnt++;
    else begin
      fail_cnt++;
      $error("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
    end
  endtask

  task automatic reinit_shadow();
    for (int i = 0; i < 64; i++) shadow[i] = init_word(i);
  endtask

  task automatic applyStimulus(input int r, input logic v, input logic w, input logic l,
                               input logic [3:0] be, input logic [AW-1:0] addr,
                               input logic [DW-1:0] wdata);
    bus.req_valid[r]           = v;
    bus.req_write[r]           = w;
    bus.req_last[r]            = l;
    bus.req_be[r*4 +: 4]       = be;
    bus.req_addr[r*AW +: AW]   = addr;
    bus.req_wdata[r*DW +: DW]  = wdata;
  endtask

  // One cycle: check the grant mid-cycle, model the accepted beat, then check the response after the edge.
  task automatic checkOutput(input string tag, input logic [NR-1:0] exp_ready);
    int            g;
    logic [3:0]    be;
    logic [AW-1:0] addr;
    logic [DW-1:0] wdata;
    rsp_t          e;
    @(negedge clock);
    check({tag, ".ready"}, 64'(bus.req_ready), 64'(exp_ready));
    if (exp_ready == '0) begin
      check({tag, ".wr_en_idle"}, 64'(bus.bram_wr_en), 64'd0);
    end else begin
      g     = exp_ready[1] ? 1 : 0;
      be    = bus.req_be[g*4 +: 4];
      addr  = bus.req_addr[g*AW +: AW];
      wdata = bus.req_wdata[g*DW +: DW];
      if (bus.req_write[g]) begin
        check({tag, ".wr_en"}, 64'(bus.bram_wr_en), 64'(be));
        check({tag, ".wr_addr"}, 64'(bus.bram_wr_addr), 64'(addr));
        check({tag, ".din"}, 64'(bus.bram_din), 64'(wdata));
        for (int b = 0; b < 4; b++)
          if (be[b]) shadow[addr][8*b +: 8] = wdata[8*b +: 8];
      end else begin
        check({tag, ".rd_wr_en"}, 64'(bus.bram_wr_en), 64'd0);
        check({tag, ".rd_addr"}, 64'(bus.bram_rd_addr), 64'(addr));
        e.id   = exp_ready;
        e.data = shadow[addr];
        sb.push_back(e);
      end
    end
    @(posedge clock);
    #1;
    if (sb.size() > 0) begin
      e = sb.pop_front();
      check({tag, ".rsp_valid"}, 64'(bus.rsp_valid), 64'(e.id));
      check({tag, ".rsp_rdata"}, 64'(bus.rsp_rdata), 64'(e.data));
    end else begin
      check({tag, ".rsp_none"}, 64'(bus.rsp_valid), 64'd0);
    end
  endtask

  initial begin
    reinit_shadow();
    bus.req_valid = '0;
    bus.req_write = '0;
    bus.req_last  = '0;
    bus.req_be    = '0;
    bus.req_addr  = '0;
    bus.req_wdata = '0;

    // Reset with every requester asking: everything stays at zero.
    reset = 1'b1;
    applyStimulus(0, 1, 0, 1, 4'h0, 6'd3, 32'h0);
    applyStimulus(1, 1, 0, 1, 4'h0, 6'd7, 32'h0);
    repeat (3) @(posedge clock);
    @(negedge clock);
    check("rst.req_ready", 64'(bus.req_ready), 64'd0);
    check("rst.rsp_valid", 64'(bus.rsp_valid), 64'd0);
    check("rst.wr_en", 64'(bus.bram_wr_en), 64'd0);
    check("rst.rd_addr", 64'(bus.bram_rd_addr), 64'd0);
    check("rst.wr_addr", 64'(bus.bram_wr_addr), 64'd0);
    check("rst.din", 64'(bus.bram_din), 64'd0);
    check("rst.rsp_rdata", 64'(bus.rsp_rdata), 64'd0);
    @(posedge clock);
    #1;
    reset = 1'b0;

    // Requester 0 first, then strict alternation of single reads.
    checkOutput("rr0", 2'b01);
    for (int i = 1; i <= 3; i++) begin
      applyStimulus(0, 1, 0, 1, 4'h0, 6'(i), 32'h0);
      applyStimulus(1, 1, 0, 1, 4'h0, 6'(40 + i), 32'h0);
      checkOutput("rr", (i % 2 == 1) ? 2'b10 : 2'b01);
    end

    // Byte masks: full write, partial overwrite, empty-mask write, then read back.
    applyStimulus(1, 0, 0, 1, 4'h0, 6'd0, 32'h0);
    applyStimulus(0, 1, 1, 1, 4'hF, 6'd5, 32'hAABB_CCDD);
    checkOutput("be_full", 2'b01);
    applyStimulus(0, 0, 0, 1, 4'h0, 6'd0, 32'h0);
    applyStimulus(1, 1, 1, 1, 4'h3, 6'd5, 32'h1122_3344);
    checkOutput("be_low", 2'b10);
    applyStimulus(1, 1, 1, 1, 4'h0, 6'd5, 32'hFFFF_FFFF);
    checkOutput("be_zero", 2'b10);
    applyStimulus(1, 0, 0, 1, 4'h0, 6'd0, 32'h0);
    applyStimulus(0, 1, 0, 1, 4'h0, 6'd5, 32'h0);
    checkOutput("be_read", 2'b01);
    check("be_value", 64'(shadow[5]), 64'h0000_0000_AABB_3344);

    // Locked burst of 4 beats by requester 1 with a 2-cycle bubble; requester 0 keeps asking.
    applyStimulus(0, 1, 0, 1, 4'h0, 6'd11, 32'h0);
    applyStimulus(1, 1, 1, 0, 4'hF, 6'd10, 32'h0BAD_F00D);
    checkOutput("lock_b1", 2'b10);
    applyStimulus(1, 1, 1, 0, 4'hF, 6'd11, 32'hC0FF_EE11);
    checkOutput("lock_b2", 2'b10);
    applyStimulus(1, 0, 0, 0, 4'h0, 6'd0, 32'h0);
    checkOutput("lock_bub1", 2'b00);
    checkOutput("lock_bub2", 2'b00);
    applyStimulus(1, 1, 0, 0, 4'h0, 6'd10, 32'h0);
    checkOutput("lock_b3", 2'b10);
    applyStimulus(1, 1, 0, 1, 4'h0, 6'd11, 32'h0);
    checkOutput("lock_b4", 2'b10);
    applyStimulus(1, 0, 0, 1, 4'h0, 6'd0, 32'h0);
    checkOutput("lock_after", 2'b01);

    // Forced release: requester 0 bursts 12 beats; requester 1 slips in once after beat 8.
    applyStimulus(0, 0, 0, 1, 4'h0, 6'd0, 32'h0);
    applyStimulus(1, 1, 1, 1, 4'hF, 6'd30, 32'h3030_3030);
    checkOutput("fr_pre", 2'b10);
    applyStimulus(1, 1, 0, 1, 4'h0, 6'd20, 32'h0);
    for (int k = 0; k < MB; k++) begin
      applyStimulus(0, 1, 1, 0, 4'hF, 6'(20 + k), 32'h1000_0000 + k);
      checkOutput("fr_beat", 2'b01);
    end
    applyStimulus(0, 1, 1, 0, 4'hF, 6'd28, 32'h1000_0008);
    checkOutput("fr_other", 2'b10);
    applyStimulus(1, 0, 0, 1, 4'h0, 6'd0, 32'h0);
    for (int k = 8; k < 12; k++) begin
      applyStimulus(0, 1, 1, (k == 11) ? 1'b1 : 1'b0, 4'hF, 6'(20 + k), 32'h1000_0000 + k);
      checkOutput("fr_resume", 2'b01);
    end

    // Reset right after a locking read is accepted: no response, lock dropped.
    applyStimulus(0, 1, 0, 0, 4'h0, 6'd3, 32'h0);
    @(negedge clock);
    check("mid.ready", 64'(bus.req_ready), 64'd1);
    @(posedge clock);
    #1;
    reset = 1'b1;
    applyStimulus(0, 0, 0, 1, 4'h0, 6'd0, 32'h0);
    reinit_shadow();
    #1;
    check("mid.rsp_valid", 64'(bus.rsp_valid), 64'd0);
    check("mid.rsp_rdata", 64'(bus.rsp_rdata), 64'd0);
    @(posedge clock);
    #1;
    reset = 1'b0;
    applyStimulus(1, 1, 0, 1, 4'h0, 6'd7, 32'h0);
    checkOutput("mid_unlocked", 2'b10);
    applyStimulus(1, 0, 0, 1, 4'h0, 6'd0, 32'h0);
    checkOutput("mid_idle", 2'b00);

    $display("[TB] failures counted: %0d", fail_cnt);
    $display("%0d/%0d checks passed", pass_cnt, check_cnt);
    $finish;
  end
endmodule
